// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered channel mux with manual select and a dwell-timed scan mode.
module mux_scan_seq #(
   parameter int CH    = 8,
   parameter int W     = 1,
   parameter int DWELL = 1,
   localparam int SW   = (CH > 2) ? $clog2(CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   input  logic [CH*W-1:0] din,
   output logic [W-1:0]    dout,
   output logic [SW-1:0]   chan,
   output logic            valid,
   output logic            wrap
);

   localparam logic [SW:0]   CHN  = (SW+1)'(CH);
   localparam logic [SW-1:0] LAST = SW'(CH - 1);
   localparam logic [7:0]    DEND = 8'(DWELL - 1);

   logic [W-1:0]  dout_q, dout_d, pick;
   logic [SW-1:0] chan_q, chan_d, ptr_q, ptr_d, eptr, idx;
   logic [7:0]    dcnt_q, dcnt_d, edcnt;
   logic          valid_q, valid_d, wrap_q, wrap_d;
   logic          pmode_q, pmode_d, pend_q, pend_d, wp_q, wp_d;
   logic          restart, in_rng, dend, last;

   // Next-state: a scan restart (mode rose, possibly while disabled) forces
   // channel 0 with a fresh dwell; the wrap pulse is held pending until the
   // sample that brings chan back to 0.
   always_comb begin
      restart = !pmode_q || pend_q;
      eptr    = restart ? '0 : ptr_q;
      edcnt   = restart ? '0 : dcnt_q;
      in_rng  = {1'b0, sel} < CHN;
      idx     = mode ? eptr : sel;
      pick    = '0;
      for (int k = 0; k < CH; k++)
         if (idx == SW'(k)) pick = din[k*W +: W];
      dend    = edcnt == DEND;
      last    = eptr == LAST;
      dout_d  = dout_q;
      chan_d  = chan_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      ptr_d   = ptr_q;
      dcnt_d  = dcnt_q;
      wp_d    = wp_q;
      pmode_d = mode;
      pend_d  = mode && !en && restart;
      if (en && !mode) begin
         dout_d  = in_rng ? pick : '0;
         chan_d  = sel;
         valid_d = in_rng;
      end
      if (en && mode) begin
         dout_d  = pick;
         chan_d  = eptr;
         valid_d = 1'b1;
         wrap_d  = wp_q && !restart;
         ptr_d   = dend ? (last ? '0 : eptr + 1'b1) : eptr;
         dcnt_d  = dend ? 8'd0 : edcnt + 8'd1;
         wp_d    = dend && last;
      end
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         ptr_q   <= '0;
         dcnt_q  <= 8'd0;
         pmode_q <= 1'b0;
         pend_q  <= 1'b0;
         wp_q    <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         ptr_q   <= ptr_d;
         dcnt_q  <= dcnt_d;
         pmode_q <= pmode_d;
         pend_q  <= pend_d;
         wp_q    <= wp_d;
      end
   end

   assign dout  = dout_q;
   assign chan  = chan_q;
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: directed scoreboard bench over several parameterisations of mux_scan_seq.
module tb_mux_scan_seq;

   logic clk = 1'b0, rst = 1'b1, rst5 = 1'b1;
   always #5 clk = ~clk;

   logic en1 = 0, mode1 = 0, d1, v1, w1;
   logic [2:0] sel1 = 0, c1;
   logic [7:0] din1 = 0;
   logic en2 = 0, mode2 = 0, v2, w2;
   logic [2:0] sel2 = 0, c2;
   logic [31:0] din2 = 0;
   logic [3:0] d2;
   logic en3 = 0, mode3 = 0, d3, v3, w3;
   logic [1:0] sel3 = 0, c3;
   logic [3:0] din3 = 0;
   logic en4 = 0, mode4 = 0, v4, w4;
   logic [2:0] sel4 = 0, c4;
   logic [19:0] din4 = 0;
   logic [3:0] d4;
   logic en5 = 0, mode5 = 0, v5, w5;
   logic [2:0] sel5 = 0, c5;
   logic [31:0] din5 = 0;
   logic [3:0] d5;

   mux_scan_seq #(.CH(8), .W(1), .DWELL(1)) u1 (.clk(clk), .rst(rst), .en(en1), .mode(mode1), .sel(sel1), .din(din1), .dout(d1), .chan(c1), .valid(v1), .wrap(w1));
   mux_scan_seq #(.CH(8), .W(4), .DWELL(1)) u2 (.clk(clk), .rst(rst), .en(en2), .mode(mode2), .sel(sel2), .din(din2), .dout(d2), .chan(c2), .valid(v2), .wrap(w2));
   mux_scan_seq #(.CH(4), .W(1), .DWELL(3)) u3 (.clk(clk), .rst(rst), .en(en3), .mode(mode3), .sel(sel3), .din(din3), .dout(d3), .chan(c3), .valid(v3), .wrap(w3));
   mux_scan_seq #(.CH(5), .W(4), .DWELL(1)) u4 (.clk(clk), .rst(rst), .en(en4), .mode(mode4), .sel(sel4), .din(din4), .dout(d4), .chan(c4), .valid(v4), .wrap(w4));
   mux_scan_seq #(.CH(8), .W(4), .DWELL(2)) u5 (.clk(clk), .rst(rst5), .en(en5), .mode(mode5), .sel(sel5), .din(din5), .dout(d5), .chan(c5), .valid(v5), .wrap(w5));

   typedef struct {
      int          id;
      string       tag;
      logic [31:0] d;
      logic [31:0] c;
      logic        v;
      logic        w;
   } exp_t;

   exp_t sb[$];
   int compared = 0, mism = 0;

   function automatic logic [65:0] obs(int id);
      case (id)
         1: return {32'(d1), 32'(c1), v1, w1};
         2: return {32'(d2), 32'(c2), v2, w2};
         3: return {32'(d3), 32'(c3), v3, w3};
         4: return {32'(d4), 32'(c4), v4, w4};
         default: return {32'(d5), 32'(c5), v5, w5};
      endcase
   endfunction

   task automatic push(int id, string tag, int d, int c, bit v, bit w);
      exp_t e;
      e.id = id; e.tag = tag; e.d = d; e.c = c; e.v = v; e.w = w;
      sb.push_back(e);
   endtask

   task automatic cmp();
      exp_t e;
      logic [65:0] o, x;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.id);
         x = {e.d, e.c, e.v, e.w};
         compared++;
         assert (o === x) else begin
            mism++;
            $error("FAIL u%0d %s: observed dout=%0h chan=%0d valid=%0b wrap=%0b, expected dout=%0h chan=%0d valid=%0b wrap=%0b",
                   e.id, e.tag, o[65:34], o[33:2], o[1], o[0], x[65:34], x[33:2], x[1], x[0]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cmp();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int i = 1; i <= 5; i++) push(i, "reset", 0, 0, 0, 0);
      cmp();
      rst = 0;
      rst5 = 0;

      // manual sweep, one-hot on channel 7
      din1 = 8'b1000_0000; en1 = 1;
      for (int s = 0; s < 8; s++) begin
         sel1 = 3'(s);
         push(1, "man8", (s == 7) ? 1 : 0, s, 1, 0);
         tick();
      end

      // full scan with wrap
      for (int k = 0; k < 8; k++) din2[k*4 +: 4] = 4'(k + 3);
      mode2 = 1; en2 = 1;
      for (int i = 0; i < 10; i++) begin
         push(2, "scan", (i % 8) + 3, i % 8, 1, i == 8);
         tick();
      end

      // dwell with an en gap, then manual and a disabled mode rise
      din3 = 4'b0101; mode3 = 1; en3 = 1;
      push(3, "dw1", 1, 0, 1, 0); tick();
      en3 = 0;
      push(3, "hold", 1, 0, 0, 0); tick();
      en3 = 1;
      push(3, "dw2", 1, 0, 1, 0); tick();
      push(3, "dw3", 1, 0, 1, 0); tick();
      push(3, "ch1", 0, 1, 1, 0); tick();
      mode3 = 0; sel3 = 2;
      push(3, "man", 1, 2, 1, 0); tick();
      mode3 = 1; en3 = 0;
      push(3, "rise_en0", 1, 2, 0, 0); tick();
      en3 = 1;
      push(3, "restart", 1, 0, 1, 0); tick();

      // out-of-range select on non-power-of-2 channel count
      for (int k = 0; k < 5; k++) din4[k*4 +: 4] = 4'(k + 9);
      en4 = 1;
      sel4 = 6; push(4, "sel6", 0, 6, 0, 0); tick();
      sel4 = 4; push(4, "sel4", 13, 4, 1, 0); tick();
      sel4 = 5; push(4, "sel5", 0, 5, 0, 0); tick();
      sel4 = 0; push(4, "sel0", 9, 0, 1, 0); tick();
      sel4 = 7; push(4, "sel7", 0, 7, 0, 0); tick();

      // scan to ptr 5, manual detour, scan restarts at 0
      for (int k = 0; k < 8; k++) din5[k*4 +: 4] = 4'(15 - k);
      mode5 = 1; en5 = 1;
      for (int i = 0; i < 10; i++) begin
         push(5, "pre", 15 - i / 2, i / 2, 1, 0);
         tick();
      end
      push(5, "p5", 10, 5, 1, 0); tick();
      mode5 = 0; sel5 = 3;
      push(5, "det1", 12, 3, 1, 0); tick();
      push(5, "det2", 12, 3, 1, 0); tick();
      mode5 = 1;
      push(5, "back0", 15, 0, 1, 0); tick();
      for (int j = 1; j <= 12; j++) begin
         push(5, "run", 15 - j / 2, j / 2, 1, 0);
         tick();
      end

      // asynchronous reset mid-dwell at ptr 6
      #3;
      rst5 = 1;
      #1;
      push(5, "arst", 0, 0, 0, 0); cmp();
      @(posedge clk);
      #1;
      push(5, "arst_hold", 0, 0, 0, 0); cmp();
      rst5 = 0;
      push(5, "rel0a", 15, 0, 1, 0); tick();
      push(5, "rel0b", 15, 0, 1, 0); tick();
      push(5, "rel1", 14, 1, 1, 0); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 The block SHALL have parameter CH, default 8: number of input channels, 2..64.
REQ-002 The block SHALL have parameter W, default 1: data width per channel, 1..32.
REQ-003 The block SHALL have parameter DWELL, default 1: enabled cycles spent on each channel in scan mode, 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: when high, the block advances and samples.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects manual mode, 1 selects scan mode.
REQ-008 The block SHALL have port sel, input, SW = max(1, clog2(CH)) bits: channel select used in manual mode.
REQ-009 The block SHALL have port din, input, CH*W bits: channel k occupies bits [k*W +: W].
REQ-010 The block SHALL have port dout, output, W bits: registered selected data.
REQ-011 The block SHALL have port chan, output, SW bits: index of the channel that produced dout.
REQ-012 The block SHALL have port valid, output, 1 bit: dout/chan hold a fresh sample taken in the previous cycle.
REQ-013 The block SHALL have port wrap, output, 1 bit: one-cycle pulse; the scan completed channel CH-1 and returned to 0.

Function
REQ-014 All outputs SHALL be registered: 1-cycle latency from sampled inputs to dout/chan/valid/wrap.
REQ-015 If en=0, the block SHALL hold dout, chan, scan pointer and dwell counter, and drive valid=0 and wrap=0 on the next edge.
REQ-016 In manual mode with en=1 and sel<CH, the block SHALL register dout=din[sel*W +: W], chan=sel and valid=1.
REQ-017 In manual mode with en=1 and sel>=CH (non-power-of-2 CH only), the block SHALL register dout=0, chan=sel and valid=0.
REQ-018 Scan mode SHALL keep an internal pointer ptr (SW bits) and a dwell counter dcnt (8 bits).
REQ-019 In scan mode with en=1, the block SHALL register dout=din[ptr*W +: W], chan=ptr and valid=1.
REQ-020 In scan mode with en=1 and dcnt<DWELL-1, the block SHALL increment dcnt.
REQ-021 In scan mode with en=1 and dcnt=DWELL-1, the block SHALL clear dcnt and advance ptr by 1.
REQ-022 When ptr=CH-1 advances, ptr SHALL wrap to 0 and the block SHALL assert wrap=1 for exactly one cycle.
REQ-023 The block SHALL register the previous mode; a 0->1 transition SHALL force ptr=0 and dcnt=0 before the first scan sample.
REQ-024 In the cycle of a 0->1 transition, that first sample SHALL be channel 0.
REQ-025 On a 1->0 transition, the block SHALL freeze ptr and dcnt (unused) and take the manual path immediately.
REQ-026 A mode transition with en=0 SHALL be recorded, and the reset of ptr/dcnt SHALL still take effect at the next cycle with en=1 in scan mode.
REQ-027 When DWELL=1, the block SHALL advance ptr every enabled cycle.
REQ-028 The block SHALL have no combinational path from any input to any output.

Reset
REQ-029 While rst=1, the block SHALL hold dout=0, chan=0, valid=0, wrap=0, ptr=0, dcnt=0 and previous-mode=0, regardless of clk.
REQ-030 When rst is asserted mid-scan, the block SHALL abort the scan; after release, scanning SHALL restart at channel 0 with a full dwell.
REQ-031 After rst deasserts, the first edge SHALL behave per REQ-015..REQ-027, with reset state as the starting point.

Verification
REQ-032 Bench SHALL cover this case: CH=8, W=1, mode=0, en=1, din=8'b1000_0000, sel=0..7 stepped each cycle -> the cycle after each sel, dout=1 only for sel=7, chan=sel, valid=1.
REQ-033 Bench SHALL cover this case: CH=8, W=4, DWELL=1, mode=1, en=1, din[k]=k+3 -> chan sequence 0,1,...,7,0; dout=chan+3; wrap=1 only in the cycle chan returns to 0.
REQ-034 Bench SHALL cover this case: CH=4, DWELL=3, scan, en toggled 1,0,1,1,1 -> chan stays 0 for 3 enabled samples then moves to 1; valid=0 in the en=0 cycle, and dout is held.
REQ-035 Bench SHALL cover this case: CH=5, manual, sel=6 -> dout=0, valid=0, chan=6; then sel=4 -> dout=din[4], valid=1.
REQ-036 Bench SHALL cover this case: scan at ptr=5, set mode=0 for 2 cycles then mode=1 -> the first scan sample is chan=0.
REQ-037 Bench SHALL cover this case: rst pulsed asynchronously between clock edges at ptr=6 -> outputs 0 immediately; after release, chan=0 with full dwell.
